// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR digit generator: maximal-length tap masks
// and FSM state encoding.
package lfsr_pkg;
  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hD008;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;
endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with runtime reseed; an all-zero seed is
// replaced by SEED so the register can never lock up.
module lfsr_core #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hD008,
  parameter logic [LFSR_W-1:0] SEED   = 16'h0009,
  parameter int                OUT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [OUT_W-1:0]  o_cand
);
  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;

  assign w_fb   = ^(r_lfsr & TAPS);
  assign o_cand = r_lfsr[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset)
      r_lfsr <= SEED;
    else if (i_seed_load)
      r_lfsr <= (i_seed == '0) ? SEED : i_seed;
    else
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
  end
endmodule

// File: rtl/lfsr_digit_gen.sv
// Bounded-latency random value generator: rejection-samples LFSR values onto
// 0..MAX_VAL with optional no-immediate-repeat and a deterministic fallback.
module lfsr_digit_gen
  import lfsr_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = TAPS_16,
  parameter logic [LFSR_W-1:0] SEED      = 16'h0009,
  parameter int                OUT_W     = 4,
  parameter int                MAX_VAL   = 9,
  parameter bit                NO_REPEAT = 1'b1,
  parameter int                MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  output logic              ready,
  output logic              rand_valid,
  output logic [OUT_W-1:0]  rand_num
);
  localparam int             TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [OUT_W-1:0] MAX_V = OUT_W'(MAX_VAL);

  if (LFSR_W < 3 || OUT_W > LFSR_W || MAX_VAL >= 2**OUT_W || MAX_VAL < 0 ||
      MAX_TRIES < 1 || SEED == '0) begin : g_param_chk
    $error("lfsr_digit_gen: illegal parameter combination");
  end

  state_t           r_state, w_next;
  logic [TRY_W-1:0] r_try, w_try_nxt;
  logic [OUT_W-1:0] r_rand_num, w_val, w_cand, w_fallback;
  logic             r_rand_valid, r_prev_valid, w_load, w_accept;

  lfsr_core #(.LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED), .OUT_W(OUT_W)) u_core (
    .clk        (clk),
    .reset      (reset),
    .i_seed_load(seed_load),
    .i_seed     (seed_in),
    .o_cand     (w_cand)
  );

  // r_rand_num doubles as the previous output; it only changes on an output.
  assign w_accept   = (w_cand <= MAX_V) &&
                      (!NO_REPEAT || !r_prev_valid || (w_cand != r_rand_num));
  assign w_fallback = !r_prev_valid ? '0 :
                      (r_rand_num == MAX_V) ? '0 : r_rand_num + OUT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_try_nxt = r_try;
    w_load    = 1'b0;
    w_val     = w_cand;
    if (seed_load) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (req) begin
          w_try_nxt = TRY_W'(1);
          if (w_accept) begin
            w_load = 1'b1;
          end else if (MAX_TRIES == 1) begin
            w_load = 1'b1;
            w_val  = w_fallback;
          end else begin
            w_next = SEARCH;
          end
        end
        SEARCH: begin
          // r_try counts completed checks, so this cycle is check r_try+1.
          w_try_nxt = r_try + TRY_W'(1);
          if (w_accept) begin
            w_load = 1'b1;
            w_next = IDLE;
          end else if (r_try == TRY_W'(MAX_TRIES - 1)) begin
            w_load = 1'b1;
            w_val  = w_fallback;
            w_next = IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ready = (r_state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_try        <= '0;
      r_rand_num   <= '0;
      r_rand_valid <= 1'b0;
      r_prev_valid <= 1'b0;
    end else begin
      r_try        <= w_try_nxt;
      r_rand_valid <= w_load;
      if (w_load) begin
        r_rand_num   <= w_val;
        r_prev_valid <= 1'b1;
      end
    end
  end

  assign rand_valid = r_rand_valid;
  assign rand_num   = r_rand_num;
endmodule

// File: tb/tb_lfsr_digit_gen.sv
// Scoreboard bench for lfsr_digit_gen: four configurations driven with
// directed requests; a negedge monitor matches every rand_valid to the queue.
module tb_lfsr_digit_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       seed_load = 1'b0;
  logic [3:0] seed_in = 4'h0;
  logic [3:0] req = 4'h0;
  logic [3:0] rdy, vld;
  logic [3:0] n_dig, n_fb, n_z;
  logic [1:0] n_nr;

  typedef struct { int id; int cyc; int val; } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  bit   rnd_mode = 1'b0;
  int   rnd_last = -1, rnd_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

  // 0: digits, 1: MAX_TRIES=2, 2: 2-bit no-repeat, 3: MAX_VAL=0
  lfsr_digit_gen #(.LFSR_W(4), .TAPS(4'hC), .SEED(4'h9), .OUT_W(4), .MAX_VAL(9),
    .NO_REPEAT(1), .MAX_TRIES(8)) u_dig (.clk(clk), .reset(reset), .seed_load(seed_load),
    .seed_in(seed_in), .req(req[0]), .ready(rdy[0]), .rand_valid(vld[0]), .rand_num(n_dig));
  lfsr_digit_gen #(.LFSR_W(4), .TAPS(4'hC), .SEED(4'h9), .OUT_W(4), .MAX_VAL(9),
    .NO_REPEAT(1), .MAX_TRIES(2)) u_fb (.clk(clk), .reset(reset), .seed_load(seed_load),
    .seed_in(seed_in), .req(req[1]), .ready(rdy[1]), .rand_valid(vld[1]), .rand_num(n_fb));
  lfsr_digit_gen #(.LFSR_W(4), .TAPS(4'hC), .SEED(4'h9), .OUT_W(2), .MAX_VAL(3),
    .NO_REPEAT(1), .MAX_TRIES(8)) u_nr (.clk(clk), .reset(reset), .seed_load(seed_load),
    .seed_in(seed_in), .req(req[2]), .ready(rdy[2]), .rand_valid(vld[2]), .rand_num(n_nr));
  lfsr_digit_gen #(.LFSR_W(4), .TAPS(4'hC), .SEED(4'h9), .OUT_W(4), .MAX_VAL(0),
    .NO_REPEAT(1), .MAX_TRIES(8)) u_z (.clk(clk), .reset(reset), .seed_load(seed_load),
    .seed_in(seed_in), .req(req[3]), .ready(rdy[3]), .rand_valid(vld[3]), .rand_num(n_z));

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_out(int id, int c, int v);
    exp_t e;
    e.id = id; e.cyc = c; e.val = v;
    sb.push_back(e);
  endtask

  task automatic mon(int id, logic v, int num);
    int idx;
    if (!v) return;
    if (rnd_mode && id == 0) begin
      chk("rnd_range", int'(num <= 9), 1);
      if (rnd_last >= 0) chk("rnd_norepeat", int'(num != rnd_last), 1);
      rnd_last = num;
      rnd_cnt++;
    end else begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
        if (idx < 0 && sb[i].id == id) idx = i;
      if (idx < 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_valid dut%0d: got value %0d at cycle %0d, expected no output",
                 id, num, cyc);
      end else begin
        chk($sformatf("value_dut%0d", id), num, sb[idx].val);
        chk($sformatf("cycle_dut%0d", id), cyc, sb[idx].cyc);
        sb.delete(idx);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, vld[0], int'(n_dig));
    mon(1, vld[1], int'(n_fb));
    mon(2, vld[2], int'(n_nr));
    mon(3, vld[3], int'(n_z));
  end

  task automatic go_cycle(int n);
    int guard = 0;
    while (cyc != n && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 1000) begin
      $display("FAIL go_cycle: timed out waiting for cycle %0d", n);
      $fatal(1);
    end
  endtask

  task automatic do_reset();
    req = 4'h0; seed_load = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic end_phase(string nm);
    chk(nm, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    // Phase 1: reset values, digit search, fallback, MAX_VAL=0
    do_reset();
    @(negedge clk);
    chk("rst_num", int'(n_dig), 0);
    chk("rst_valid", int'(vld), 0);
    chk("rst_ready", int'(rdy), 15);
    req[3] = 1'b1; expect_out(3, 8, 0);
    go_cycle(1); req[3] = 1'b0;
    go_cycle(3); req[0] = 1'b1; req[1] = 1'b1;
    expect_out(0, 6, 5); expect_out(1, 5, 0);
    go_cycle(4); req[0] = 1'b0; req[1] = 1'b0;
    @(negedge clk); chk("search_ready", int'(rdy[0]), 0);
    go_cycle(8); req[3] = 1'b1; expect_out(3, 16, 0);
    go_cycle(9); req[3] = 1'b0;
    go_cycle(20); end_phase("pending_p1");

    // Phase 2: no-repeat with 2-bit output, reissue during valid
    do_reset();
    go_cycle(6); req[2] = 1'b1; expect_out(2, 7, 3);
    go_cycle(7); expect_out(2, 10, 2);
    go_cycle(8); req[2] = 1'b0;
    go_cycle(14); end_phase("pending_p2");

    // Phase 3: zero-seed guard and nonzero reseed (prev kept across reseed)
    do_reset();
    go_cycle(2); seed_load = 1'b1; seed_in = 4'h0;
    go_cycle(3); seed_load = 1'b0;
    go_cycle(6); req[0] = 1'b1; req[1] = 1'b1;
    expect_out(0, 9, 5); expect_out(1, 8, 0);
    go_cycle(7); req[0] = 1'b0; req[1] = 1'b0;
    go_cycle(12); seed_load = 1'b1; seed_in = 4'hD;
    go_cycle(13); seed_load = 1'b0; req[0] = 1'b1; expect_out(0, 18, 7);
    go_cycle(14); req[0] = 1'b0;
    go_cycle(22); end_phase("pending_p3");

    // Phase 4: seed_load abort, then reset abort
    do_reset();
    go_cycle(3); req[0] = 1'b1;
    go_cycle(4); req[0] = 1'b0; seed_load = 1'b1; seed_in = 4'h0;
    @(negedge clk); chk("abort_ready_before", int'(rdy[0]), 0);
    go_cycle(5); seed_load = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", int'(rdy[0]), 1);
    chk("abort_no_valid", int'(vld[0]), 0);
    req[0] = 1'b1; expect_out(0, 6, 9);
    go_cycle(6); req[0] = 1'b0;
    go_cycle(8); req[0] = 1'b1;
    go_cycle(9); req[0] = 1'b0; reset = 1'b0;
    @(negedge clk); chk("rstabort_ready_before", int'(rdy[0]), 0);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("rstabort_num", int'(n_dig), 0);
    chk("rstabort_valid", int'(vld[0]), 0);
    chk("rstabort_ready", int'(rdy[0]), 1);
    go_cycle(12); end_phase("pending_p4");

    // Phase 5: req held high for 20 cycles
    do_reset();
    req[0] = 1'b1;
    expect_out(0, 1, 9);  expect_out(0, 2, 3);  expect_out(0, 3, 6);
    expect_out(0, 6, 5);  expect_out(0, 8, 7);  expect_out(0, 12, 8);
    expect_out(0, 13, 1); expect_out(0, 14, 2); expect_out(0, 15, 4);
    expect_out(0, 16, 9); expect_out(0, 17, 3); expect_out(0, 18, 6);
    expect_out(0, 21, 5);
    go_cycle(20); req[0] = 1'b0;
    go_cycle(26); end_phase("pending_p5");

    // Phase 6: random requests, range and no-repeat properties
    do_reset();
    rnd_mode = 1'b1; rnd_last = -1; rnd_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      req[0] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    req[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1; rnd_mode = 1'b0;
    chk("rnd_outputs_seen", int'(rnd_cnt > 20), 1);
    end_phase("pending_p6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
